traffic_phase_ctrl: RTL and testbench

- Two-way intersection sequencer: steps NS/EW lights through green, yellow and all-red phases, with one countdown per phase timed by the 1 Hz tick.
- Adds a latched pedestrian request that shortens NS green and grants a walk signal during EW green.
- Adds a night mode that flashes yellow.
- Sits above the light-driver outputs and the seven-segment count display; owns all phase timing.

---
 rtl/traffic_phase_ctrl.sv | 161 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with a pedestrian walk request and a
// flashing-yellow night mode. All phase timing is driven by a synchronised 1 Hz tick.
module traffic_phase_ctrl #(
  parameter int T_NS_G = 30,
  parameter int T_EW_G = 20,
  parameter int T_Y    = 3,
  parameter int T_AR   = 2,
  parameter int T_PED  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [5:0] count,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_e;

  localparam logic [5:0] D_NS_G = 6'(T_NS_G);
  localparam logic [5:0] D_EW_G = 6'(T_EW_G);
  localparam logic [5:0] D_Y    = 6'(T_Y);
  localparam logic [5:0] D_AR   = 6'(T_AR);
  localparam logic [5:0] D_PED  = 6'(T_PED);

  state_e     state_q, state_d, nxt_s;
  logic [5:0] count_q, count_d;
  logic       ped_q, ped_d, walk_q, walk_d, flash_q, flash_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic       sync1_q, sync2_q, prev_q, tick_s;

  function automatic logic [5:0] dur(input state_e s);
    case (s)
      NS_G:    dur = D_NS_G;
      NS_Y:    dur = D_Y;
      AR1:     dur = D_AR;
      EW_G:    dur = D_EW_G;
      EW_Y:    dur = D_Y;
      AR2:     dur = D_AR;
      default: dur = 6'd0;
    endcase
  endfunction

  // Returns {ns_light, ew_light} for a state; FLASH shows yellow only in its lit half.
  function automatic logic [5:0] lights(input state_e s, input logic fl);
    case (s)
      NS_G:    lights = {3'b001, 3'b100};
      NS_Y:    lights = {3'b010, 3'b100};
      EW_G:    lights = {3'b100, 3'b001};
      EW_Y:    lights = {3'b100, 3'b010};
      FLASH:   lights = {1'b0, fl, 1'b0, 1'b0, fl, 1'b0};
      default: lights = {3'b100, 3'b100};
    endcase
  endfunction

  assign tick_s = sync2_q & ~prev_q;

  // clk_1Hz synchroniser and rising-edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= clk_1Hz;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Successor state for the current phase
  always_comb begin
    nxt_s = AR2;
    case (state_q)
      NS_G:    nxt_s = NS_Y;
      NS_Y:    nxt_s = AR1;
      AR1:     nxt_s = EW_G;
      EW_G:    nxt_s = EW_Y;
      EW_Y:    nxt_s = AR2;
      AR2:     nxt_s = night_mode ? FLASH : NS_G;
      default: nxt_s = AR2;
    endcase
  end

  // Phase stepping; the pedestrian latch is the only state that moves without a tick
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    walk_d  = walk_q;
    flash_d = flash_q;
    ped_d   = ped_q | ped_req;
    if (tick_s && enable) begin
      if (state_q == FLASH) begin
        if (night_mode) begin
          flash_d = ~flash_q;
        end else begin
          state_d = AR2;
          count_d = D_AR;
          flash_d = 1'b0;
        end
      end else if (state_q == NS_G && ped_q && count_q > D_PED) begin
        count_d = D_PED;
      end else if (count_q > 6'd1) begin
        count_d = count_q - 6'd1;
      end else begin
        state_d = nxt_s;
        count_d = dur(nxt_s);
        if (nxt_s == EW_G) begin
          walk_d = ped_q;
          ped_d  = ped_req;
        end else begin
          walk_d = 1'b0;
        end
      end
    end else begin
      state_d = state_q;
    end
    {ns_d, ew_d} = lights(state_d, flash_d);
  end

  // Phase state and registered light/count outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= AR2;
      count_q <= D_AR;
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
      flash_q <= 1'b0;
      ns_q    <= 3'b100;
      ew_q    <= 3'b100;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ped_q   <= ped_d;
      walk_q  <= walk_d;
      flash_q <= flash_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign walk     = walk_q;
  assign count    = count_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: a per-tick phase model checked against
// the DUT on every falling clk edge, plus literal expectations at key points.
module tb_traffic_phase_ctrl;
  localparam int T_NS_G = 5, T_EW_G = 4, T_Y = 2, T_AR = 1, T_PED = 2;

  logic clk = 1'b0, reset = 1'b0, clk_1hz = 1'b0, enable = 1'b1;
  logic ped_req = 1'b0, night_mode = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;
  logic [5:0] count;

  int checks = 0, errors = 0;

  // Model: phase index 0..6, remaining ticks, pedestrian latch, walk lamp, flash bit.
  int m_state = 5, m_count = T_AR, m_ped = 0, m_walk = 0, m_flash = 0;
  int dur_tab [7] = '{T_NS_G, T_Y, T_AR, T_EW_G, T_Y, T_AR, 0};
  logic [2:0] ns_tab [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
  logic [2:0] ew_tab [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};

  traffic_phase_ctrl #(.T_NS_G(T_NS_G), .T_EW_G(T_EW_G), .T_Y(T_Y), .T_AR(T_AR), .T_PED(T_PED)) dut (
    .clk(clk), .reset(reset), .clk_1Hz(clk_1hz), .enable(enable), .ped_req(ped_req),
    .night_mode(night_mode), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .count(count), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_ns();
    return (m_state == 6) ? {1'b0, m_flash[0], 1'b0} : ns_tab[m_state];
  endfunction
  function automatic logic [2:0] m_ew();
    return (m_state == 6) ? {1'b0, m_flash[0], 1'b0} : ew_tab[m_state];
  endfunction

  task automatic model_reset();
    m_state = 5; m_count = T_AR; m_ped = 0; m_walk = 0; m_flash = 0;
  endtask

  // One qualifying tick worth of phase behaviour.
  task automatic model_step();
    int nxt;
    if (!enable) return;
    if (m_state == 6) begin
      if (night_mode) m_flash = 1 - m_flash;
      else begin m_state = 5; m_count = T_AR; m_flash = 0; end
    end else if (m_state == 0 && m_ped == 1 && m_count > T_PED) begin
      m_count = T_PED;
    end else if (m_count > 1) begin
      m_count = m_count - 1;
    end else begin
      nxt = (m_state == 5) ? (night_mode ? 6 : 0) : m_state + 1;
      if (nxt == 3) begin m_walk = m_ped; m_ped = 0; end
      else m_walk = 0;
      m_state = nxt;
      m_count = dur_tab[nxt];
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    chk("phase", phase, m_state);
    chk("count", count, m_count);
    chk("walk", walk, m_walk);
    chk("ns_light", ns_light, m_ns());
    chk("ew_light", ew_light, m_ew());
  end

  // A clk_1Hz rising edge becomes a tick acted on at the third clk edge after it.
  task automatic do_tick();
    @(negedge clk); clk_1hz = 1'b1;
    repeat (3) @(posedge clk);
    #1 model_step();
    repeat (2) @(negedge clk);
    clk_1hz = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_ped();
    @(negedge clk); ped_req = 1'b1;
    @(posedge clk); #1 m_ped = 1;
    @(negedge clk); ped_req = 1'b0;
  endtask

  task automatic tick_until(input int st, input int cnt, input string name);
    int n = 0;
    while (!(m_state == st && (cnt < 0 || m_count == cnt)) && n < 40) begin
      do_tick(); n++;
    end
    chk({name, "_reached"}, (m_state == st) ? 1 : 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_phase", phase, 5);
    chk("rst_count", count, 1);
    chk("rst_ns", ns_light, 3'b100);
    chk("rst_ew", ew_light, 3'b100);

    // Free-running cycle
    do_tick();
    chk("t1_phase", phase, 0);
    chk("t1_count", count, 5);
    chk("t1_ns", ns_light, 3'b001);
    repeat (19) do_tick();

    // Pedestrian request at NS_G count 5 truncates to T_PED and grants walk in EW_G
    tick_until(0, 5, "ped_nsg");
    pulse_ped();
    do_tick();
    chk("ped_trunc_count", count, 2);
    tick_until(3, -1, "ped_ewg");
    chk("ped_walk", walk, 1);
    repeat (8) do_tick();

    // Request during EW_G: served in the next cycle
    tick_until(3, -1, "ewg_req");
    pulse_ped();
    chk("ewg_walk_held", walk, 0);
    tick_until(0, 5, "ewg_next_nsg");
    do_tick();
    chk("ewg_trunc", count, 2);
    tick_until(3, -1, "ewg_next_ewg");
    chk("ewg_walk_next", walk, 1);

    // enable=0 freezes state and count; frozen ticks are lost
    tick_until(0, 3, "en_nsg");
    enable = 1'b0;
    repeat (3) do_tick();
    chk("en_hold_count", count, 3);
    chk("en_hold_phase", phase, 0);
    enable = 1'b1;
    do_tick();
    chk("en_resume_count", count, 2);

    // Night mode: finish to AR2, flash, then return through AR2
    night_mode = 1'b1;
    tick_until(6, -1, "night_flash");
    chk("flash_dark_ns", ns_light, 3'b000);
    do_tick();
    chk("flash_lit_ns", ns_light, 3'b010);
    chk("flash_lit_ew", ew_light, 3'b010);
    chk("flash_count", count, 0);
    repeat (3) do_tick();
    night_mode = 1'b0;
    do_tick();
    chk("night_exit_phase", phase, 5);
    chk("night_exit_count", count, 1);
    do_tick();
    chk("night_nsg_count", count, 5);

    // Asynchronous reset mid-clk in EW_Y
    tick_until(4, -1, "rst_ewy");
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("arst_ns", ns_light, 3'b100);
    chk("arst_ew", ew_light, 3'b100);
    chk("arst_count", count, 1);
    chk("arst_walk", walk, 0);
    model_reset();
    repeat (2) begin
      @(negedge clk); clk_1hz = 1'b1;
      repeat (4) @(negedge clk); clk_1hz = 1'b0;
      repeat (4) @(negedge clk);
    end
    @(posedge clk); #2 reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_phase", phase, 5);
    do_tick();
    chk("post_rst_tick", phase, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
